hbridge_motor_sequencer: RTL
============================

# hbridge_motor_sequencer

Per-motor sequencer that drives one Pmod H-bridge channel's EN (PWM) and DIR pins from a duty/direction command handshake. It enforces a dead-time brake on every direction reversal and applies glitch-free duty updates only at PWM period boundaries. It also counts rising edges of the S-A feedback line. One instance per motor sits between the AXI-GPIO/register layer and the Pmod bridge connector, replacing the free-running PWM source and raw GPIO direction bit.

## Interface
- PWM_BITS, 8, duty/counter width; PWM period = 2^PWM_BITS − 1 cycles
- DEADTIME_CYCLES, 1000, cycles EN is held low before DIR may change (10 µs at 100 MHz); must be ≥ 1
- FB_BITS, 16, feedback counter width
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- enable  in  1  motor enable; 0 forces EN low
- cmd_valid  in  1  command offered
- cmd_ready  out  1  command accepted on clk when cmd_valid && cmd_ready
- cmd_duty  in  PWM_BITS  requested duty (0 = off, 2^PWM_BITS−1 = always on)
- cmd_dir  in  1  requested direction
- pwm_out  out  1  to EN pin
- dir_out  out  1  to DIR pin
- feedback  in  1  asynchronous S-A sense input
- fb_clear  in  1  synchronous clear of fb_count
- fb_count  out  FB_BITS  saturating rising-edge count
- braking  out  1  high while in BRAKE or SWITCH

## Operation
- Reset values: state IDLE, pwm_out 0, dir_out 0, duty_active 0, duty_pending 0, pwm counter 0, fb_count 0, braking 0, cmd_ready 1.
- States: IDLE (EN low), RUN (PWM active), BRAKE (EN low, dead-time countdown), SWITCH (one cycle; DIR updated).
- cmd_ready = 1 in IDLE and RUN, 0 in BRAKE and SWITCH.
- Accepted command with cmd_dir == dir_out: duty_pending ← cmd_duty; state unchanged.
- Accepted command with cmd_dir ≠ dir_out (from IDLE or RUN): duty_pending ← cmd_duty, dir_target ← cmd_dir, go to BRAKE, load deadtime counter with DEADTIME_CYCLES−1. Reversal always brakes, even from IDLE.
- BRAKE: pwm_out 0; decrement counter; at 0 go to SWITCH. enable and commands are ignored.
- SWITCH: dir_out ← dir_target, duty_active ← duty_pending, pwm counter ← 0; next state RUN if enable, else IDLE.
- IDLE → RUN when enable = 1: pwm counter ← 0, duty_active ← duty_pending.
- RUN → IDLE when enable = 0. pwm_out goes 0 on the next edge. dir_out is held.
- PWM counter in RUN counts 0 … 2^PWM_BITS−2, then wraps to 0. At the wrap, duty_active ← duty_pending.
- pwm_out is registered: next pwm_out = (cnt < duty_active) in RUN, 0 otherwise. This makes duty 0 constantly low and duty max constantly high.
- Feedback path: 2-flop synchronizer, then rising-edge detect. fb_count increments, saturating at 2^FB_BITS−1. If fb_clear and an edge occur in the same cycle, the result is 1.

## Timing
- Duty update latency in RUN: new duty is visible on pwm_out starting the cycle after the next counter wrap. The current period always completes.
- Reversal from RUN: pwm_out is 0 from the edge after acceptance.
  - EN low before the dir_out change: exactly DEADTIME_CYCLES + 1 cycles (BRAKE plus SWITCH).
  - First possible pwm_out high: 1 cycle after SWITCH.
- Feedback latency: fb_count updates 3 clk edges after a feedback rising edge.
- Reset asserted mid-BRAKE: all outputs return immediately (asynchronously) to reset values. dir_out = 0 is safe because EN = 0.

## Structure
- Shared package hbridge_pkg holds:
  - state enum {IDLE, RUN, BRAKE, SWITCH}
  - default PWM_BITS, DEADTIME_CYCLES, FB_BITS constants
  - pwm_period(PWM_BITS) function
- One sub-module, feedback_edge_counter: synchronizer, edge detect, saturating counter, clear.

## Test plan
- Reset release, enable = 1, command duty = 64 dir = 0 → pwm_out high 64 of every 255 cycles; dir_out stays 0; cmd_ready stays 1.
- In RUN with duty 64, command duty 200 mid-period → remainder of that period keeps 64; next period is high 200 cycles.
- In RUN dir 0, command dir 1 duty 128 with DEADTIME_CYCLES = 10 → pwm_out 0 the next cycle; dir_out flips 11 cycles after acceptance; cmd_ready low throughout; PWM resumes at duty 128.
- Duty 0 and duty 255 → pwm_out constant 0 and constant 1 across ≥ 3 periods.
- 5 feedback pulses, then fb_clear coinciding with a 6th edge → fb_count reaches 5, then reads 1. Drive to saturation with FB_BITS = 4 → holds 15.
- Reset asserted during BRAKE; enable dropped in RUN → outputs go to reset values immediately; pwm_out 0 the cycle after enable falls, with dir_out held.

Source files
------------

// File: rtl/hbridge_pkg.sv
// hbridge_pkg: shared types and defaults for the H-bridge motor sequencer.
//   state_t    - sequencer states (IDLE, RUN, BRAKE, SWITCH)
//   DEFAULT_*  - default widths and dead-time length
//   pwm_period - PWM period in cycles for a given counter width
package hbridge_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        BRAKE  = 2'd2,
        SWITCH = 2'd3
    } state_t;

    localparam int DEFAULT_PWM_BITS        = 32'sd8;
    localparam int DEFAULT_DEADTIME_CYCLES = 32'sd1000;
    localparam int DEFAULT_FB_BITS         = 32'sd16;

    // The counter skips its all-ones value so that a duty of all-ones is
    // always on, giving a period of 2^bits - 1 cycles.
    function automatic int pwm_period(input int bits);
        return int'((32'd1 << bits) - 32'd1);
    endfunction

endpackage

// File: rtl/hbridge_motor_sequencer_feedback_edge_counter.sv
// feedback_edge_counter: counts rising edges of an asynchronous sense line.
//   clk, reset  - system clock, asynchronous active-high reset
//   feedback    - asynchronous input, double-flop synchronized here
//   fb_clear    - synchronous clear; a coincident edge leaves the count at 1
//   fb_count    - saturating rising-edge count (registered)
module feedback_edge_counter #(
    parameter int FB_BITS = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               feedback,
    input  logic               fb_clear,
    output logic [FB_BITS-1:0] fb_count
);

    localparam logic [FB_BITS-1:0] FB_ONE = FB_BITS'(1);

    logic               sync1_r;
    logic               sync2_r;
    logic               prev_r;
    logic               edge_s;
    logic [FB_BITS-1:0] count_r;
    logic [FB_BITS-1:0] count_s;

    // Synchronizer chain plus one delayed copy for edge detection.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
            prev_r  <= 1'b0;
        end else begin
            sync1_r <= feedback;
            sync2_r <= sync1_r;
            prev_r  <= sync2_r;
        end
    end

    // Next count: clear wins over hold, but an edge during clear counts as 1.
    always_comb begin
        edge_s  = sync2_r & ~prev_r;
        count_s = count_r;
        if (fb_clear) begin
            count_s = edge_s ? FB_ONE : '0;
        end else if (edge_s && !(&count_r)) begin
            count_s = count_r + FB_ONE;
        end else begin
            count_s = count_r;
        end
    end

    // Count register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_r <= '0;
        end else begin
            count_r <= count_s;
        end
    end

    assign fb_count = count_r;

endmodule

// File: rtl/hbridge_motor_sequencer.sv
// hbridge_motor_sequencer: drives one H-bridge channel (EN = PWM, DIR) from a
// duty/direction command handshake, with a dead-time brake on every reversal
// and duty changes applied only at PWM period boundaries.
//   clk, reset           - system clock, asynchronous active-high reset
//   enable               - motor enable; low forces EN low
//   cmd_valid/cmd_ready  - command handshake (cmd_duty, cmd_dir)
//   pwm_out, dir_out     - registered EN and DIR pin drives
//   feedback, fb_clear   - S-A sense input and synchronous count clear
//   fb_count             - saturating count of feedback rising edges
//   braking              - high in BRAKE and SWITCH
module hbridge_motor_sequencer
    import hbridge_pkg::*;
#(
    parameter int PWM_BITS        = DEFAULT_PWM_BITS,
    parameter int DEADTIME_CYCLES = DEFAULT_DEADTIME_CYCLES,
    parameter int FB_BITS         = DEFAULT_FB_BITS
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [PWM_BITS-1:0] cmd_duty,
    input  logic                cmd_dir,
    output logic                pwm_out,
    output logic                dir_out,
    input  logic                feedback,
    input  logic                fb_clear,
    output logic [FB_BITS-1:0]  fb_count,
    output logic                braking
);

    localparam int DT_W = (DEADTIME_CYCLES > 32'sd1) ? $clog2(DEADTIME_CYCLES) : 32'sd1;
    localparam logic [DT_W-1:0]     DT_LOAD  = DT_W'(DEADTIME_CYCLES - 32'sd1);
    localparam logic [DT_W-1:0]     DT_ONE   = DT_W'(1);
    localparam logic [PWM_BITS-1:0] CNT_LAST = PWM_BITS'(pwm_period(PWM_BITS) - 32'sd1);
    localparam logic [PWM_BITS-1:0] CNT_ONE  = PWM_BITS'(1);

    state_t              state_r,        state_s;
    logic                dir_r,          dir_s;
    logic                dir_target_r,   dir_target_s;
    logic [PWM_BITS-1:0] duty_active_r,  duty_active_s;
    logic [PWM_BITS-1:0] duty_pending_r, duty_pending_s;
    logic [PWM_BITS-1:0] cnt_r,          cnt_s;
    logic [DT_W-1:0]     dt_cnt_r,       dt_cnt_s;
    logic                pwm_r,          pwm_s;
    logic                ready_r,        ready_s;
    logic                braking_r,      braking_s;
    logic                accept_s;

    // Next-state, datapath and registered-output decode.
    always_comb begin
        state_s        = state_r;
        dir_s          = dir_r;
        dir_target_s   = dir_target_r;
        duty_active_s  = duty_active_r;
        duty_pending_s = duty_pending_r;
        cnt_s          = cnt_r;
        dt_cnt_s       = dt_cnt_r;
        accept_s       = cmd_valid && ready_r;

        case (state_r)
            IDLE, RUN: begin
                if (accept_s && (cmd_dir != dir_r)) begin
                    // Any reversal, even from IDLE, goes through the brake.
                    duty_pending_s = cmd_duty;
                    dir_target_s   = cmd_dir;
                    dt_cnt_s       = DT_LOAD;
                    state_s        = BRAKE;
                end else begin
                    if (accept_s) begin
                        duty_pending_s = cmd_duty;
                    end else begin
                        duty_pending_s = duty_pending_r;
                    end
                    if (state_r == IDLE) begin
                        if (enable) begin
                            cnt_s         = '0;
                            duty_active_s = duty_pending_r;
                            state_s       = RUN;
                        end else begin
                            state_s = IDLE;
                        end
                    end else if (!enable) begin
                        state_s = IDLE;
                    end else if (cnt_r == CNT_LAST) begin
                        // Period boundary: the only point a new duty takes effect.
                        cnt_s         = '0;
                        duty_active_s = duty_pending_r;
                    end else begin
                        cnt_s = cnt_r + CNT_ONE;
                    end
                end
            end
            BRAKE: begin
                if (dt_cnt_r == '0) begin
                    state_s = SWITCH;
                end else begin
                    dt_cnt_s = dt_cnt_r - DT_ONE;
                end
            end
            SWITCH: begin
                dir_s         = dir_target_r;
                duty_active_s = duty_pending_r;
                cnt_s         = '0;
                state_s       = enable ? RUN : IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase

        // EN only follows the comparator while staying in RUN, so leaving RUN
        // (disable or reversal) drops EN on that same edge.
        pwm_s     = (state_r == RUN) && (state_s == RUN) && (cnt_r < duty_active_r);
        ready_s   = (state_s == IDLE) || (state_s == RUN);
        braking_s = (state_s == BRAKE) || (state_s == SWITCH);
    end

    // State and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r        <= IDLE;
            dir_r          <= 1'b0;
            dir_target_r   <= 1'b0;
            duty_active_r  <= '0;
            duty_pending_r <= '0;
            cnt_r          <= '0;
            dt_cnt_r       <= '0;
            pwm_r          <= 1'b0;
            ready_r        <= 1'b1;
            braking_r      <= 1'b0;
        end else begin
            state_r        <= state_s;
            dir_r          <= dir_s;
            dir_target_r   <= dir_target_s;
            duty_active_r  <= duty_active_s;
            duty_pending_r <= duty_pending_s;
            cnt_r          <= cnt_s;
            dt_cnt_r       <= dt_cnt_s;
            pwm_r          <= pwm_s;
            ready_r        <= ready_s;
            braking_r      <= braking_s;
        end
    end

    assign pwm_out   = pwm_r;
    assign dir_out   = dir_r;
    assign cmd_ready = ready_r;
    assign braking   = braking_r;

    feedback_edge_counter #(
        .FB_BITS (FB_BITS)
    ) u_fb (
        .clk      (clk),
        .reset    (reset),
        .feedback (feedback),
        .fb_clear (fb_clear),
        .fb_count (fb_count)
    );

endmodule
